muldiv_ex: RTL and testbench
============================

MULDIV_EX -- requirements
Module: muldiv_ex

Interface
REQ-001 SHALL have parameter: XLEN, default 64, operand/result width; legal values 32 and 64.
REQ-002 SHALL have port: clk_i  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start_i  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: op_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: word_i  input  1  RV64 *W variant; ignored when XLEN=32.
REQ-007 SHALL have port: rs1_i, rs2_i  input  XLEN  operands; captured on accept.
REQ-008 SHALL have port: kill_i  input  1  pipeline flush; aborts operation.
REQ-009 SHALL have port: busy_o  output  1  high in CALC; stalls the execute stage.
REQ-010 SHALL have port: done_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: result_o  output  XLEN  result; feeds the memory stage as ALU result.
REQ-012 SHALL have port: err_o  output  1  unsupported op; valid with done_o.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; accept occurs on a clock edge in IDLE with start_i=1.
REQ-014 SHALL ignore start_i in CALC and DONE.
REQ-015 SHALL use an iterative radix-2 datapath with one bit per cycle: shift-add multiply, restoring divide.
REQ-016 SHALL set N=XLEN iterations, or N=32 when word_i=1 and XLEN=64.
REQ-017 SHALL hold CALC for exactly N cycles, enter DONE at the next edge, and assert done_o for exactly one cycle in DONE.
REQ-018 SHALL place done_o N+1 cycles after the accept edge.
REQ-019 SHALL hold result_o and err_o stable from DONE until the next accept.
REQ-020 SHALL handle MULH/MULHSU/MULHU via a 2*XLEN product, returning the upper XLEN bits; signed operands are handled by magnitude and a final negate.
REQ-021 SHALL treat word_i=1 as follows: operands are the low 32 bits (sign- or zero-extended per op), and result bits 31:0 are sign-extended to 64; word_i with op 001-011 executes as MULW.
REQ-022 SHALL, on divide by zero, skip CALC (done_o on the cycle after accept) and return quotient all-ones and remainder equal to dividend.
REQ-023 SHALL, on signed overflow (most-negative / -1, per width), skip CALC and return quotient equal to dividend and remainder 0.
REQ-024 SHALL follow sign rules: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-025 SHALL, when kill_i=1 at an edge in any state, enter IDLE and suppress done_o; result_o keeps its previous value.
REQ-026 SHALL let kill_i win when kill_i and start_i are high in the same IDLE cycle (no accept).
REQ-027 SHALL keep busy_o high in CALC only, and low in IDLE and DONE.

Reset
REQ-028 SHALL, while rst_ni=0, asynchronously force state IDLE, busy_o=0, done_o=0, err_o=0, result_o=0, and clear the iteration counter.
REQ-029 SHALL abort any operation on reset mid-operation, with no done_o after release.
REQ-030 SHALL accept start_i on the first rising edge after rst_ni deasserts.

Configuration
REQ-031 SHALL gate divide with macro MULDIV_DIV_EN; when defined, ops 100-111 behave per REQ-015 through REQ-024, and err_o is always 0.
REQ-032 SHALL, without MULDIV_DIV_EN, omit all divider logic; ops 100-111 complete with done_o one cycle after accept, result_o=0 and err_o=1; multiply behaviour is unchanged.

Verification
REQ-033 SHALL cover, with XLEN=64: MUL with rs1=7, rs2=-3 -> done_o at accept+65, result_o=0xFFFF_FFFF_FFFF_FFEB.
REQ-034 SHALL cover: MULHU with rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> result_o=0xFFFF_FFFF_FFFF_FFFE; MULH with -1 * -1 -> 0.
REQ-035 SHALL cover, with MULDIV_DIV_EN: DIV -7/2 -> result_o -3; REM -7/2 -> -1; DIVU x/0 -> all-ones at accept+2; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
REQ-036 SHALL cover: word_i=1, MUL rs1=0x7FFF_FFFF, rs2=2 -> result_o=0xFFFF_FFFF_FFFF_FFFE, with done_o at accept+33.
REQ-037 SHALL cover: kill_i at CALC cycle 10 -> no done_o, busy_o=0 next cycle; rst_ni low mid-CALC -> all outputs 0 immediately; start_i while busy -> ignored.
REQ-038 SHALL cover, without MULDIV_DIV_EN: DIV 10/2 -> done_o at accept+2, result_o=0, err_o=1.

Source files
------------

// File: rtl/muldiv_ex_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
interface muldiv_ex_if #(
  parameter int XLEN = 64
);
  logic            start_i;
  logic [2:0]      op_i;
  logic            word_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            kill_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic            err_o;

  modport master (output start_i, op_i, word_i, rs1_i, rs2_i, kill_i,
                  input  busy_o, done_o, result_o, err_o);
  modport slave  (input  start_i, op_i, word_i, rs1_i, rs2_i, kill_i,
                  output busy_o, done_o, result_o, err_o);
endinterface

// File: rtl/muldiv_ex.sv
// Iterative radix-2 RISC-V mul/div unit; divide only with MULDIV_DIV_EN. done_o N+1 cycles after accept
// (2 for div-by-zero/overflow/unsupported). No backpressure: busy_o stalls execute, start_i taken only in IDLE.
module muldiv_ex #(
  parameter int XLEN = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  muldiv_ex_if.slave io
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
    return r;
  endfunction

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              busy_q, done_q, err_q;
  logic [XLEN-1:0]   result_q;
  logic              word_q, hi_q, neg_q, special_q, spec_err_q;
  logic [XLEN-1:0]   spec_q, mplier, mul_res, fin;
  logic [2*XLEN-1:0] acc, mcand, acc_nx, prod;

  // Operand decode on the accept cycle: extension, signedness and magnitudes.
  logic            word, is_div, sgn1, sgn2, a_neg, b_neg;
  logic            special, spec_err;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, spec_res;

  always_comb begin
    word   = (XLEN == 64) && io.word_i;
    is_div = io.op_i[2];
    if (is_div) begin
      sgn1 = !io.op_i[0];
      sgn2 = !io.op_i[0];
    end else begin
      sgn1 = !word && (io.op_i[1:0] == 2'b01 || io.op_i[1:0] == 2'b10);
      sgn2 = !word && (io.op_i[1:0] == 2'b01);
    end
    a_ext = word ? ext32(io.rs1_i, sgn1) : io.rs1_i;
    b_ext = word ? ext32(io.rs2_i, sgn2) : io.rs2_i;
    a_neg = sgn1 && a_ext[XLEN-1];
    b_neg = sgn2 && b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] most_neg;
  logic [XLEN-1:0] rem, quo, dvsr, rem_nx, quo_nx, q_s, r_s, div_res;
  logic [XLEN:0]   part, trial;
  logic            div_q, rem_sel;

  always_comb begin
    most_neg           = '0;
    most_neg[XLEN-1]   = 1'b1;
    if (word) for (int i = 31; i < XLEN; i++) most_neg[i] = 1'b1;
    special  = 1'b0;
    spec_err = 1'b0;
    spec_res = '0;
    if (is_div && b_ext == '0) begin
      special  = 1'b1;
      spec_res = io.op_i[1] ? a_ext : '1;
    end else if (is_div && sgn1 && a_ext == most_neg && b_ext == '1) begin
      special  = 1'b1;
      spec_res = io.op_i[1] ? '0 : a_ext;
    end
  end

  // Restoring step: shift one dividend bit into the partial remainder, subtract if it fits.
  always_comb begin
    part    = {rem, quo[XLEN-1]};
    trial   = part - {1'b0, dvsr};
    rem_nx  = trial[XLEN] ? part[XLEN-1:0] : trial[XLEN-1:0];
    quo_nx  = {quo[XLEN-2:0], ~trial[XLEN]};
    q_s     = neg_q ? -quo_nx : quo_nx;
    r_s     = neg_q ? -rem_nx : rem_nx;
    div_res = rem_sel ? r_s : q_s;
  end
`else
  always_comb begin
    special  = is_div;
    spec_err = is_div;
    spec_res = '0;
  end
`endif

  always_comb begin
    acc_nx  = mplier[0] ? acc + mcand : acc;
    prod    = neg_q ? -acc_nx : acc_nx;
    mul_res = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    fin     = mul_res;
`ifdef MULDIV_DIV_EN
    if (div_q) fin = div_res;
`endif
    if (special_q) fin = spec_q;
    if (word_q)    fin = ext32(fin, 1'b1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cnt        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
      word_q     <= 1'b0;
      hi_q       <= 1'b0;
      neg_q      <= 1'b0;
      special_q  <= 1'b0;
      spec_err_q <= 1'b0;
      spec_q     <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
`ifdef MULDIV_DIV_EN
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      div_q      <= 1'b0;
      rem_sel    <= 1'b0;
`endif
    end else if (io.kill_i) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (io.start_i) begin
            state      <= CALC;
            busy_q     <= 1'b1;
            word_q     <= word;
            hi_q       <= !is_div && !word && (io.op_i[1:0] != 2'b00);
            neg_q      <= (is_div && io.op_i[1]) ? a_neg : (a_neg ^ b_neg);
            special_q  <= special;
            spec_err_q <= spec_err;
            spec_q     <= spec_res;
            acc        <= '0;
            mcand      <= {{XLEN{1'b0}}, a_mag};
            mplier     <= b_mag;
            // Special cases resolve after a single CALC cycle.
            cnt        <= special ? '0 : (word ? CW'(31) : CW'(XLEN - 1));
`ifdef MULDIV_DIV_EN
            div_q      <= is_div;
            rem_sel    <= io.op_i[1];
            rem        <= '0;
            quo        <= word ? (a_mag << (XLEN - 32)) : a_mag;
            dvsr       <= b_mag;
`endif
          end
        end
        CALC: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
`ifdef MULDIV_DIV_EN
          rem    <= rem_nx;
          quo    <= quo_nx;
`endif
          if (cnt == '0) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= fin;
            err_q    <= spec_err_q;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.busy_o   = busy_q;
  assign io.done_o   = done_q;
  assign io.result_o = result_q;
  assign io.err_o    = err_q;
endmodule

// File: tb/tb_muldiv_ex.sv
// Directed bench for muldiv_ex (XLEN=64) with an arithmetic reference model and a per-cycle checker.
module tb_muldiv_ex;
  localparam int XLEN = 64;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  muldiv_ex_if #(.XLEN(XLEN)) io ();
  muldiv_ex #(.XLEN(XLEN)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .io(io));

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic straight from the ISA definitions.
  function automatic void model(input logic [2:0] op, input logic word, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] res, output logic err,
                                output int lat);
    logic [127:0] sa, sb, p;
    logic [31:0]  r32;
`ifdef MULDIV_DIV_EN
    logic         sgn;
    logic [63:0]  x, y, mn, q, rm;
`endif
    err = 1'b0;
    lat = word ? 33 : 65;
    res = '0;
    if (!op[2]) begin
      if (word) begin
        r32 = a[31:0] * b[31:0];
        res = {{32{r32[31]}}, r32};
      end else begin
        sa  = (op == 3'd1 || op == 3'd2) ? {{64{a[63]}}, a} : {64'b0, a};
        sb  = (op == 3'd1) ? {{64{b[63]}}, b} : {64'b0, b};
        p   = sa * sb;
        res = (op == 3'd0) ? p[63:0] : p[127:64];
      end
    end else begin
`ifdef MULDIV_DIV_EN
      sgn = !op[0];
      if (word) begin
        x  = sgn ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
        y  = sgn ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
        mn = 64'hFFFF_FFFF_8000_0000;
      end else begin
        x  = a;
        y  = b;
        mn = 64'h8000_0000_0000_0000;
      end
      if (y == 64'd0) begin
        q = '1; rm = x; lat = 2;
      end else if (sgn && x == mn && y == '1) begin
        q = x; rm = '0; lat = 2;
      end else if (sgn) begin
        q  = $signed(x) / $signed(y);
        rm = $signed(x) % $signed(y);
      end else begin
        q  = x / y;
        rm = x % y;
      end
      res = op[1] ? rm : q;
      if (word) res = {{32{res[31]}}, res[31:0]};
`else
      res = '0;
      err = 1'b1;
      lat = 2;
`endif
    end
  endfunction

  logic        act = 1'b0;
  int          acc_cyc, exp_lat;
  logic [63:0] exp_res, last_res;
  logic        exp_err;
  string       cur;

  // Single compare process: busy/done every cycle of an operation, result/err on done and after.
  always @(negedge clk_i) begin
    int j;
    if (act) begin
      j = cyc - acc_cyc;
      if (j < exp_lat - 1) begin
        chk({cur, " busy"}, 64'(io.busy_o), 64'd1);
        chk({cur, " done early"}, 64'(io.done_o), 64'd0);
      end else if (j == exp_lat - 1) begin
        chk({cur, " busy at done"}, 64'(io.busy_o), 64'd0);
        chk({cur, " done"}, 64'(io.done_o), 64'd1);
        chk({cur, " result"}, io.result_o, exp_res);
        chk({cur, " err"}, 64'(io.err_o), 64'(exp_err));
      end else begin
        chk({cur, " done pulse width"}, 64'(io.done_o), 64'd0);
        chk({cur, " result held"}, io.result_o, exp_res);
        act = 1'b0;
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b, input logic lit,
                        input logic [63:0] lit_r, input int lit_l, input logic poke,
                        input logic rel);
    logic [63:0] r;
    logic        e;
    int          l;
    model(op, word, a, b, r, e, l);
    if (lit) begin
      chk({name, " model result"}, r, lit_r);
      chk({name, " model latency"}, 64'(l), 64'(lit_l));
    end
    @(negedge clk_i);
    io.start_i = 1'b1; io.op_i = op; io.word_i = word; io.rs1_i = a; io.rs2_i = b;
    if (rel) rst_ni = 1'b1;
    cur = name; exp_res = r; exp_err = e; exp_lat = l;
    @(posedge clk_i); #1;
    acc_cyc = cyc; act = 1'b1;
    io.start_i = 1'b0; io.rs1_i = 64'hDEAD_BEEF_0BAD_F00D; io.rs2_i = 64'd5;
    if (poke) begin
      repeat (4) @(posedge clk_i);
      #1 io.start_i = 1'b1; io.op_i = 3'b011;
      repeat (3) @(posedge clk_i);
      #1 io.start_i = 1'b0;
    end
    for (int t = 0; t < 200 && act; t++) @(posedge clk_i);
    if (act) begin
      nvec++; nerr++;
      $display("FAIL %s: no completion within 200 cycles", name);
      act = 1'b0;
    end
    last_res = r;
  endtask

  initial begin
    logic seen;
    io.start_i = 1'b0; io.op_i = 3'b000; io.word_i = 1'b0;
    io.rs1_i = '0; io.rs2_i = '0; io.kill_i = 1'b0;
    #1;
    chk("reset busy", 64'(io.busy_o), 64'd0);
    chk("reset done", 64'(io.done_o), 64'd0);
    chk("reset result", io.result_o, 64'd0);
    chk("reset err", 64'(io.err_o), 64'd0);
    repeat (3) @(posedge clk_i);

    // Released together with start: the first edge after release must accept.
    run_op("MUL 7*-3", 3'b000, 1'b0, 64'd7, -64'sd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b0, 1'b1);
    run_op("MULHU max*max", 3'b011, 1'b0, '1, '1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0, 1'b0);
    run_op("MULH -1*-1", 3'b001, 1'b0, '1, '1, 1'b1, 64'd0, 65, 1'b0, 1'b0);
    run_op("MULW 7fffffff*2", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b0, 1'b0);
    run_op("MULHSU -1*2", 3'b010, 1'b0, '1, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0, 1'b0);
    run_op("MULH min*min", 3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, '0, 0, 1'b0, 1'b0);
    run_op("MUL start-while-busy", 3'b000, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9, 1'b0, '0, 0, 1'b1, 1'b0);
    run_op("MULH word as MULW", 3'b001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0003, 1'b0, '0, 0, 1'b0, 1'b0);
`ifdef MULDIV_DIV_EN
    run_op("DIV -7/2", 3'b100, 1'b0, -64'sd7, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0, 1'b0);
    run_op("REM -7/2", 3'b110, 1'b0, -64'sd7, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0, 1'b0);
    run_op("DIVU x/0", 3'b101, 1'b0, 64'h1234, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0, 1'b0);
    run_op("DIV min/-1", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b1, 64'h8000_0000_0000_0000, 2, 1'b0, 1'b0);
    run_op("REMU x/0", 3'b111, 1'b0, 64'h55AA, 64'd0, 1'b0, '0, 0, 1'b0, 1'b0);
    run_op("DIVU big", 3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd7, 1'b0, '0, 0, 1'b0, 1'b0);
    run_op("REMW -100/7", 3'b110, 1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7, 1'b0, '0, 0, 1'b0, 1'b0);
    run_op("DIVW min/-1", 3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, '0, 0, 1'b0, 1'b0);
`else
    run_op("DIV 10/2 unsupported", 3'b100, 1'b0, 64'd10, 64'd2, 1'b1, 64'd0, 2, 1'b0, 1'b0);
    run_op("REMU unsupported", 3'b111, 1'b1, 64'd9, 64'd0, 1'b0, '0, 0, 1'b0, 1'b0);
`endif
    run_op("MUL after div", 3'b000, 1'b0, 64'd12345, 64'd678, 1'b0, '0, 0, 1'b0, 1'b0);

    // Kill in CALC cycle 10.
    @(negedge clk_i);
    io.start_i = 1'b1; io.op_i = 3'b000; io.word_i = 1'b0; io.rs1_i = 64'd3; io.rs2_i = 64'd5;
    @(posedge clk_i); #1 io.start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    chk("kill busy before", 64'(io.busy_o), 64'd1);
    io.kill_i = 1'b1;
    @(posedge clk_i); #1 io.kill_i = 1'b0;
    chk("kill busy after", 64'(io.busy_o), 64'd0);
    chk("kill done after", 64'(io.done_o), 64'd0);
    chk("kill result kept", io.result_o, last_res);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk_i);
      if (io.done_o) seen = 1'b1;
    end
    chk("kill no done", 64'(seen), 64'd0);

    // Kill and start together in IDLE: no accept.
    @(negedge clk_i);
    io.start_i = 1'b1; io.kill_i = 1'b1;
    @(posedge clk_i); #1 io.start_i = 1'b0; io.kill_i = 1'b0;
    chk("kill+start busy", 64'(io.busy_o), 64'd0);
    @(negedge clk_i);
    chk("kill+start done", 64'(io.done_o), 64'd0);

    // Reset mid-CALC clears outputs at once and the aborted op never completes.
    @(negedge clk_i);
    io.start_i = 1'b1; io.op_i = 3'b011; io.rs1_i = '1; io.rs2_i = 64'd3;
    @(posedge clk_i); #1 io.start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst busy", 64'(io.busy_o), 64'd0);
    chk("rst done", 64'(io.done_o), 64'd0);
    chk("rst result", io.result_o, 64'd0);
    chk("rst err", 64'(io.err_o), 64'd0);
    repeat (2) @(posedge clk_i);
    run_op("MULHU after reset", 3'b011, 1'b0, 64'hFFFF_0000_0000_0001, 64'h0001_0000_0000_0000, 1'b0, '0, 0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
